mul_result_reader: RTL and testbench

Read-side counterpart to the MiniAlu `MUL` sequence. `MUL` writes a 32-bit product into data RAM as four consecutive 16-bit words, each `{8'b0, byte}`, least-significant byte first. This block fetches those four words through one RAM read port, reassembles the 32-bit product, and presents it with a valid/ack handshake. While the result is pending, it also rotates the four bytes onto the 8 board LEDs for Spartan-3E bring-up.

---
 rtl/mul_result_reader_pkg.sv | 19 +
 rtl/dwell_timer.sv | 46 ++++
 rtl/mul_result_reader.sv | 152 +++++++++++++++
 tb/tb_mul_result_reader.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_result_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mul_result_reader_pkg
// Description : Shared state encodings and constants for the MUL result reader.
// Revision    : 1.0 - initial release
// ============================================================================
package mul_result_reader_pkg;

    typedef enum logic [1:0] {
        MRR_IDLE  = 2'd0,
        MRR_READ  = 2'd1,
        MRR_DRAIN = 2'd2,
        MRR_DONE  = 2'd3
    } mrr_state_t;

    localparam int MRR_NBYTES = 4;

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ============================================================================
// Module      : dwell_timer
// Description : Enabled counter that pulses oTick once every DWELL_CYCLES
//               enabled cycles; iClear restarts the count.
// Revision    : 1.0 - initial release
// ============================================================================
module dwell_timer #(
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic Clock,
    input  logic Reset,
    input  logic iClear,
    input  logic iEnable,
    output logic oTick
);

    localparam int c_cnt_w = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(DWELL_CYCLES - 1);

    logic [c_cnt_w-1:0] r_count_q;
    logic [c_cnt_w-1:0] r_count_d;
    logic               w_tick;

    always_comb begin
        w_tick    = iEnable && (r_count_q == c_last);
        r_count_d = r_count_q;
        if (iClear) begin
            r_count_d = '0;
        end else if (iEnable) begin
            r_count_d = w_tick ? '0 : r_count_q + c_cnt_w'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= r_count_d;
        end
    end

    assign oTick = w_tick;

endmodule
`default_nettype wire

// File: rtl/mul_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : mul_result_reader
// Description : Fetches four {8'b0,byte} RAM words written by MUL, reassembles
//               the 32-bit product and rotates its bytes onto the LEDs.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_result_reader
    import mul_result_reader_pkg::*;
#(
    parameter int ADDR_WIDTH   = 8,
    parameter int DWELL_CYCLES = 25_000_000
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iStart,
    input  logic [ADDR_WIDTH-1:0] iBaseAddress,
    output logic [ADDR_WIDTH-1:0] oReadAddress,
    input  logic [15:0]           iReadData,
    output logic                  oBusy,
    output logic                  oValid,
    output logic [31:0]           oWord,
    input  logic                  iAck,
    output logic [7:0]            oLed
);

    mrr_state_t                  r_state_q, r_state_d;
    logic [ADDR_WIDTH-1:0]       r_base_q,  r_base_d;
    logic [1:0]                  r_idx_q,   r_idx_d;
    logic [MRR_NBYTES-1:0][7:0]  r_stage_q, r_stage_d;
    logic [31:0]                 r_word_q,  r_word_d;
    logic                        r_valid_q, r_valid_d;
    logic                        r_busy_q,  r_busy_d;
    logic [7:0]                  r_led_q,   r_led_d;
    logic [1:0]                  r_sel_q,   r_sel_d;

    logic                        w_tick;
    logic                        w_timer_clear;
    logic                        w_timer_en;
    logic [1:0]                  w_sel_nxt;

    assign w_sel_nxt = r_sel_q + 2'd1;

    always_comb begin
        r_state_d     = r_state_q;
        r_base_d      = r_base_q;
        r_idx_d       = r_idx_q;
        r_stage_d     = r_stage_q;
        r_word_d      = r_word_q;
        r_valid_d     = r_valid_q;
        r_busy_d      = r_busy_q;
        r_led_d       = r_led_q;
        r_sel_d       = r_sel_q;
        w_timer_clear = 1'b0;
        w_timer_en    = 1'b0;

        case (r_state_q)
            MRR_IDLE: begin
                if (iStart) begin
                    r_state_d = MRR_READ;
                    r_base_d  = iBaseAddress;
                    r_idx_d   = 2'd0;
                    r_busy_d  = 1'b1;
                end
            end
            MRR_READ: begin
                // Read data lags the address by one cycle, so it lands in byte idx-1.
                if (r_idx_q != 2'd0) begin
                    r_stage_d[r_idx_q - 2'd1] = iReadData[7:0];
                end
                if (r_idx_q == 2'(MRR_NBYTES - 1)) begin
                    r_state_d = MRR_DRAIN;
                end else begin
                    r_idx_d = r_idx_q + 2'd1;
                end
            end
            MRR_DRAIN: begin
                r_stage_d[MRR_NBYTES-1] = iReadData[7:0];
                r_word_d      = {iReadData[7:0], r_stage_q[2], r_stage_q[1], r_stage_q[0]};
                r_valid_d     = 1'b1;
                r_busy_d      = 1'b0;
                r_state_d     = MRR_DONE;
                r_sel_d       = 2'd0;
                r_led_d       = r_stage_q[0];
                w_timer_clear = 1'b1;
            end
            MRR_DONE: begin
                if (iStart) begin
                    r_state_d = MRR_READ;
                    r_base_d  = iBaseAddress;
                    r_idx_d   = 2'd0;
                    r_busy_d  = 1'b1;
                    r_valid_d = 1'b0;
                end else if (iAck) begin
                    r_state_d = MRR_IDLE;
                    r_valid_d = 1'b0;
                end else begin
                    // The display only advances while the result stays held.
                    w_timer_en = 1'b1;
                    if (w_tick) begin
                        r_sel_d = w_sel_nxt;
                        r_led_d = r_word_q[{w_sel_nxt, 3'b000} +: 8];
                    end
                end
            end
            default: r_state_d = MRR_IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state_q <= MRR_IDLE;
            r_base_q  <= '0;
            r_idx_q   <= '0;
            r_stage_q <= '0;
            r_word_q  <= '0;
            r_valid_q <= 1'b0;
            r_busy_q  <= 1'b0;
            r_led_q   <= '0;
            r_sel_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_base_q  <= r_base_d;
            r_idx_q   <= r_idx_d;
            r_stage_q <= r_stage_d;
            r_word_q  <= r_word_d;
            r_valid_q <= r_valid_d;
            r_busy_q  <= r_busy_d;
            r_led_q   <= r_led_d;
            r_sel_q   <= r_sel_d;
        end
    end

    dwell_timer #(
        .DWELL_CYCLES (DWELL_CYCLES)
    ) u_dwell_timer (
        .Clock   (Clock),
        .Reset   (Reset),
        .iClear  (w_timer_clear),
        .iEnable (w_timer_en),
        .oTick   (w_tick)
    );

    assign oReadAddress = ((r_state_q == MRR_READ) || (r_state_q == MRR_DRAIN))
                        ? r_base_q + ADDR_WIDTH'(r_idx_q) : '0;
    assign oBusy        = r_busy_q;
    assign oValid       = r_valid_q;
    assign oWord        = r_word_q;
    assign oLed         = r_led_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_result_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_result_reader
// Description : Scoreboard bench for mul_result_reader with a registered RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_result_reader;

    localparam int AW = 8;
    localparam int DW = 3;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          iStart;
    logic          iAck;
    logic [AW-1:0] iBaseAddress;
    logic [AW-1:0] oReadAddress;
    logic [15:0]   iReadData;
    logic          oBusy;
    logic          oValid;
    logic [31:0]   oWord;
    logic [7:0]    oLed;

    mul_result_reader #(
        .ADDR_WIDTH   (AW),
        .DWELL_CYCLES (DW)
    ) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iStart       (iStart),
        .iBaseAddress (iBaseAddress),
        .oReadAddress (oReadAddress),
        .iReadData    (iReadData),
        .oBusy        (oBusy),
        .oValid       (oValid),
        .oWord        (oWord),
        .iAck         (iAck),
        .oLed         (oLed)
    );

    always #5 Clock = ~Clock;

    logic [15:0] mem [256];
    always @(posedge Clock) iReadData <= mem[oReadAddress];

    int cyc = 0;
    always @(posedge Clock) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    typedef struct {
        logic [31:0] word;
        int          due;
    } exp_t;
    exp_t sb[$];

    bit          active     = 1'b0;
    int          e0         = 0;
    int          last_start = -100;
    logic [7:0]  m_base     = 8'h00;
    bit          mon_en     = 1'b0;
    int          done_cyc   = 0;
    logic [31:0] cur_word   = 32'h0;
    bit          prev_valid = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [31:0] expect_word(input logic [7:0] b);
        return {mem[b + 8'd3][7:0], mem[b + 8'd2][7:0], mem[b + 8'd1][7:0], mem[b][7:0]};
    endfunction

    function automatic logic [7:0] shown_byte(input int c);
        int sel;
        sel = ((c - done_cyc) / DW) % 4;
        return cur_word[8*sel +: 8];
    endfunction

    // A start is accepted unless a read begun fewer than 6 edges ago is still in flight.
    task automatic drive_edge(input bit s, input bit a, input logic [7:0] b);
        iStart = s;
        iAck = a;
        iBaseAddress = b;
        @(posedge Clock);
        #1;
        iStart = 1'b0;
        iAck = 1'b0;
        if (s && (cyc - last_start >= 6)) begin
            last_start = cyc;
            e0 = cyc;
            active = 1'b1;
            m_base = b;
            sb.push_back('{expect_word(b), cyc + 5});
        end
    endtask

    task automatic idle(input int n);
        repeat (n) drive_edge(1'b0, 1'b0, 8'h00);
    endtask

    task automatic do_ack();
        logic [7:0] exp_led;
        if (((cyc + 1 - done_cyc) % DW) == 0) idle(1);
        exp_led = shown_byte(cyc);
        drive_edge(1'b0, 1'b1, 8'h00);
        chk("valid_after_ack", {31'b0, oValid}, 32'h0);
        chk("word_after_ack", oWord, cur_word);
        idle(4);
        chk("led_frozen", {24'b0, oLed}, {24'b0, exp_led});
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        iStart = 1'b0;
        iAck = 1'b0;
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        active = 1'b0;
        last_start = -100;
        sb.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, oBusy}, 32'h0);
        chk({tag, "_valid"}, {31'b0, oValid}, 32'h0);
        chk({tag, "_word"}, oWord, 32'h0);
        chk({tag, "_led"}, {24'b0, oLed}, 32'h0);
        chk({tag, "_addr"}, {24'b0, oReadAddress}, 32'h0);
    endtask

    always @(negedge Clock) begin
        int         k;
        bit         eb;
        logic [7:0] ea;
        exp_t       e;
        if (mon_en) begin
            k  = cyc - e0;
            eb = active && (k >= 0) && (k <= 4);
            ea = !eb ? 8'h00 : m_base + 8'((k > 3) ? 3 : k);
            chk("busy", {31'b0, oBusy}, {31'b0, eb});
            chk("addr", {24'b0, oReadAddress}, {24'b0, ea});
            if (eb) chk("valid_low_in_read", {31'b0, oValid}, 32'h0);
            if (oValid && !prev_valid) begin
                if (sb.size() == 0) begin
                    total_cnt++;
                    $display("FAIL unexpected_valid: got word 0x%0h expected no completion (cycle %0d)", oWord, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("word", oWord, e.word);
                    chk("latency", cyc, e.due);
                    done_cyc = cyc;
                    cur_word = e.word;
                end
            end
            if (oValid) chk("led", {24'b0, oLed}, {24'b0, shown_byte(cyc)});
            prev_valid = oValid;
        end
    end

    initial begin
        logic [7:0] b;
        Reset = 1'b1;
        iStart = 1'b0;
        iAck = 1'b0;
        iBaseAddress = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
        chk_zero("reset");
        mon_en = 1'b1;

        // Basic product plus a full LED rotation, then ack.
        mem[8'h10] = 16'h0078; mem[8'h11] = 16'h0056;
        mem[8'h12] = 16'h0034; mem[8'h13] = 16'h0012;
        drive_edge(1'b1, 1'b0, 8'h10);
        idle(5);
        chk("basic_word", oWord, 32'h12345678);
        idle(13);
        do_ack();

        // Address wrap past the top of RAM.
        mem[8'hFE] = 16'h00AA; mem[8'hFF] = 16'h00BB;
        mem[8'h00] = 16'h00CC; mem[8'h01] = 16'h00DD;
        drive_edge(1'b1, 1'b0, 8'hFE);
        idle(6);
        chk("wrap_word", oWord, 32'hDDCCBBAA);
        do_ack();

        // Upper data bits must be ignored.
        mem[8'h40] = 16'hFF78; mem[8'h41] = 16'hA556;
        mem[8'h42] = 16'h3C34; mem[8'h43] = 16'h0112;
        drive_edge(1'b1, 1'b0, 8'h40);
        idle(6);
        chk("upper_ignored_word", oWord, 32'h12345678);
        do_ack();

        // Start pulses during READ and DRAIN are ignored; start+ack in DONE restarts.
        drive_edge(1'b1, 1'b0, 8'h10);
        repeat (3) drive_edge(1'b1, 1'b0, 8'h40);
        idle(1);
        drive_edge(1'b1, 1'b0, 8'h40);
        idle(2);
        drive_edge(1'b1, 1'b1, 8'hFE);
        idle(6);
        chk("restart_word", oWord, 32'hDDCCBBAA);
        do_ack();

        // Reset two edges after a start aborts everything.
        drive_edge(1'b1, 1'b0, 8'h10);
        idle(1);
        do_reset();
        chk_zero("abort");
        idle(6);
        drive_edge(1'b1, 1'b0, 8'h40);
        idle(6);
        do_ack();

        // Randomized products, sometimes restarted straight from DONE.
        for (int n = 0; n < 20; n++) begin
            b = 8'($urandom);
            for (int i = 0; i < 4; i++) mem[8'(b + 8'(i))] = 16'($urandom);
            drive_edge(1'b1, 1'b0, b);
            idle($urandom_range(5, 12));
            if ($urandom_range(0, 1) == 0) do_ack();
        end

        idle(8);
        chk("scoreboard_empty", sb.size(), 32'h0);
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
